centroid_zone_tracker: RTL and testbench
========================================

Name: centroid_zone_tracker

Overview:
- Per-frame mask tracker. Consumes the threshold mask with pixel coordinates.
- Produces the mask centroid, plus a debounced "dominant horizontal zone" code for the game-state input.
- Generalises the single-centroid and fixed-key-input blocks with parametrised zone count, a minimum-mass gate, multi-frame debounce and overrun detection.

Parameters:
- H_WIDTH, 11, width of x_in/x_out.
- V_WIDTH, 10, width of y_in/y_out.
- H_ACTIVE, 1024, active pixels per line. Must be a power of two.
- ZONES, 4, number of equal-width horizontal zones. Power of two, 2..16.
- MIN_PIXELS, 64, minimum mask count for a frame to be reported.
- STABLE_FRAMES, 3, consecutive frames with the same dominant zone before the zone is declared valid. Range 1..15.

Ports:
- clk_in, input, 1, pixel clock.
- rst_in, input, 1, reset. Asynchronous, active-high.
- x_in, input, H_WIDTH, pixel column.
- y_in, input, V_WIDTH, pixel row.
- valid_in, input, 1, mask bit for the current pixel.
- tabulate_in, input, 1, single-cycle end-of-frame strobe.
- x_out, output, H_WIDTH, centroid x.
- y_out, output, V_WIDTH, centroid y.
- valid_out, output, 1, one-cycle pulse when x_out/y_out update.
- zone_out, output, $clog2(ZONES), debounced dominant zone.
- zone_valid_out, output, 1, zone_out is stable.
- busy_out, output, 1, divide/scan in progress.
- overrun_out, output, 1, sticky: a frame was dropped.

Behaviour:
- Reset: every output and internal register goes to 0. State is IDLE.
- Widths:
  - COUNT_W = H_WIDTH+V_WIDTH.
  - sum_x is H_WIDTH+COUNT_W bits; sum_y is V_WIDTH+COUNT_W bits. Neither can overflow.
  - Per-zone counters are COUNT_W bits.
- Accumulate (every state):
  - If valid_in and x_in < H_ACTIVE: count+1, sum_x+=x_in, sum_y+=y_in, zone_cnt[x_in >> log2(H_ACTIVE/ZONES)]+1.
  - Pixels with x_in >= H_ACTIVE are ignored.
- tabulate_in in IDLE (cycle T):
  - Snapshot count, sums and zone counts.
  - Clear the accumulators. A valid pixel in cycle T counts toward the new frame.
  - If snapshot count < MIN_PIXELS: no valid_out; stable counter goes to 0; zone_valid_out goes to 0; stay in IDLE.
  - Otherwise go to DIVIDE; busy_out=1 from T+1.
- DIVIDE:
  - Two parallel restoring dividers, sum_x/count and sum_y/count, one quotient bit per cycle.
  - DIV_CYCLES = H_WIDTH+COUNT_W iterations (32 at defaults), running T+1..T+DIV_CYCLES.
  - The sum_y divider is zero-extended to the same length. Quotients truncate.
  - In parallel, ZONES cycles of argmax scan over the zone counts. Ties resolve to the lowest index.
- REPORT (T+DIV_CYCLES+1):
  - x_out/y_out load the quotients; valid_out=1 for this cycle only.
  - Debounce: if argmax equals the previous frame's argmax, stable_cnt+1 (saturating at STABLE_FRAMES); else stable_cnt=1.
  - When stable_cnt reaches STABLE_FRAMES: zone_out=argmax, zone_valid_out=1.
  - When argmax changes: zone_valid_out=0, and zone_out holds its old value.
  - Return to IDLE; busy_out=0.
- tabulate_in while busy_out=1: accumulators are still cleared, that frame is discarded, and overrun_out=1 until reset. The in-flight division completes unaffected.
- rst_in mid-DIVIDE: immediate abort to IDLE with all registers cleared. No valid_out follows.
- x_out, y_out and zone_out hold their values between reports.

Optional Feature:
- Macro: CENTROID_BBOX_EN.
- Defined:
  - Adds outputs bbox_xmin_out and bbox_xmax_out (H_WIDTH) and bbox_ymin_out and bbox_ymax_out (V_WIDTH).
  - These track the min/max coordinates of the counted pixels, and are snapshot and updated on the same valid_out pulse.
  - Running min registers are initialised to all-ones and max registers to 0 at each frame start.
  - The outputs reset to 0.
- Not defined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- 64 mask pixels at (100,50), then tabulate at T -> valid_out exactly at T+33; x_out=100, y_out=50; zone_out unchanged, zone_valid_out=0 (stable_cnt=1).
- 63 mask pixels, then tabulate -> no valid_out, busy_out stays 0, zone_valid_out=0.
- Three frames, each with 100 pixels at x=600 and 10 at x=100 (defaults, zone width 256) -> after the third report zone_out=2, zone_valid_out=1. A fourth frame dominated by x=100 -> zone_valid_out=0, zone_out stays 2.
- Equal counts (80 each) in zones 1 and 3, for three frames -> zone_out=1.
- Second tabulate 10 cycles after the first (mid-DIVIDE) -> overrun_out=1 and stays high; the first frame still reports correctly; the second frame produces no valid_out.
- Assert rst_in at T+15 during DIVIDE -> outputs 0 at once, no valid_out; the next frame with 64 pixels at (7,9) reports x_out=7, y_out=9.

Source files
------------

// File: rtl/centroid_zone_tracker.sv
// centroid_zone_tracker: per-frame mask centroid plus a debounced dominant horizontal zone.
// Optional bounding-box outputs are enabled with `define CENTROID_BBOX_EN.
module centroid_zone_tracker #(
  parameter int H_WIDTH       = 11,
  parameter int V_WIDTH       = 10,
  parameter int H_ACTIVE      = 1024,
  parameter int ZONES         = 4,
  parameter int MIN_PIXELS    = 64,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [H_WIDTH-1:0]        x_in,
  input  logic [V_WIDTH-1:0]        y_in,
  input  logic                      valid_in,
  input  logic                      tabulate_in,
  output logic [H_WIDTH-1:0]        x_out,
  output logic [V_WIDTH-1:0]        y_out,
  output logic                      valid_out,
  output logic [$clog2(ZONES)-1:0]  zone_out,
  output logic                      zone_valid_out,
  output logic                      busy_out,
  output logic                      overrun_out
`ifdef CENTROID_BBOX_EN
  ,
  output logic [H_WIDTH-1:0]        bbox_xmin_out,
  output logic [H_WIDTH-1:0]        bbox_xmax_out,
  output logic [V_WIDTH-1:0]        bbox_ymin_out,
  output logic [V_WIDTH-1:0]        bbox_ymax_out
`endif
);
  localparam int COUNT_W = H_WIDTH + V_WIDTH;
  localparam int DW      = H_WIDTH + COUNT_W;
  localparam int YW      = V_WIDTH + COUNT_W;
  localparam int ZW      = $clog2(ZONES);
  localparam int ZSH     = $clog2(H_ACTIVE / ZONES);
  localparam int IW      = $clog2(DW);
  localparam logic [H_WIDTH:0]     HA   = (H_WIDTH + 1)'(H_ACTIVE);
  localparam logic [COUNT_W-1:0]   MINP = COUNT_W'(MIN_PIXELS);
  localparam logic [IW-1:0]        LAST = IW'(DW - 1);
  localparam logic [IW:0]          ZN   = (IW + 1)'(ZONES);
  localparam logic [3:0]           SF   = 4'(STABLE_FRAMES);

  typedef enum logic {IDLE, DIVIDE} state_t;
  state_t state;

  logic               hit;
  logic [ZW-1:0]      zidx;
  logic [COUNT_W-1:0] count, div, rem_x, rem_y, rx_n, ry_n, zcur, best_cnt;
  logic [DW-1:0]      sum_x, qx, qy, qx_n, qy_n;
  logic [YW-1:0]      sum_y;
  logic [COUNT_W-1:0] zone_cnt [ZONES];
  logic [COUNT_W-1:0] snap_zone [ZONES];
  logic [COUNT_W:0]   tx, ty;
  logic               gx, gy;
  logic [IW-1:0]      iter;
  logic [ZW-1:0]      best, prev_arg;
  logic [3:0]         stable_cnt, sc_n;

  assign hit  = valid_in && ({1'b0, x_in} < HA);
  assign zidx = ZW'(x_in >> ZSH);

  // A pixel arriving with the end-of-frame strobe seeds the next frame.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      count <= '0;
      sum_x <= '0;
      sum_y <= '0;
      for (int z = 0; z < ZONES; z++) zone_cnt[z] <= '0;
    end else if (tabulate_in) begin
      count <= COUNT_W'(hit);
      sum_x <= hit ? DW'(x_in) : '0;
      sum_y <= hit ? YW'(y_in) : '0;
      for (int z = 0; z < ZONES; z++) zone_cnt[z] <= COUNT_W'(hit && zidx == ZW'(z));
    end else if (hit) begin
      count <= count + COUNT_W'(1);
      sum_x <= sum_x + DW'(x_in);
      sum_y <= sum_y + YW'(y_in);
      zone_cnt[zidx] <= zone_cnt[zidx] + COUNT_W'(1);
    end

`ifdef CENTROID_BBOX_EN
  logic [H_WIDTH-1:0] xmin, xmax, sxmin, sxmax;
  logic [V_WIDTH-1:0] ymin, ymax, symin, symax;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      xmin <= '1;
      xmax <= '0;
      ymin <= '1;
      ymax <= '0;
    end else if (tabulate_in) begin
      xmin <= hit ? x_in : '1;
      xmax <= hit ? x_in : '0;
      ymin <= hit ? y_in : '1;
      ymax <= hit ? y_in : '0;
    end else if (hit) begin
      xmin <= x_in < xmin ? x_in : xmin;
      xmax <= x_in > xmax ? x_in : xmax;
      ymin <= y_in < ymin ? y_in : ymin;
      ymax <= y_in > ymax ? y_in : ymax;
    end
`endif

  // Restoring division step shared by both dividers, plus the debounce next-count.
  always_comb begin
    tx   = {rem_x, qx[DW-1]};
    ty   = {rem_y, qy[DW-1]};
    gx   = tx >= {1'b0, div};
    gy   = ty >= {1'b0, div};
    rx_n = COUNT_W'(gx ? tx - {1'b0, div} : tx);
    ry_n = COUNT_W'(gy ? ty - {1'b0, div} : ty);
    qx_n = {qx[DW-2:0], gx};
    qy_n = {qy[DW-2:0], gy};
    zcur = snap_zone[iter[ZW-1:0]];
    sc_n = best != prev_arg ? 4'd1 : stable_cnt == SF ? SF : stable_cnt + 4'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state          <= IDLE;
      iter           <= '0;
      div            <= '0;
      rem_x          <= '0;
      rem_y          <= '0;
      qx             <= '0;
      qy             <= '0;
      best           <= '0;
      best_cnt       <= '0;
      prev_arg       <= '0;
      stable_cnt     <= '0;
      x_out          <= '0;
      y_out          <= '0;
      valid_out      <= 1'b0;
      zone_out       <= '0;
      zone_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      overrun_out    <= 1'b0;
      for (int z = 0; z < ZONES; z++) snap_zone[z] <= '0;
`ifdef CENTROID_BBOX_EN
      sxmin <= '0;
      sxmax <= '0;
      symin <= '0;
      symax <= '0;
      bbox_xmin_out <= '0;
      bbox_xmax_out <= '0;
      bbox_ymin_out <= '0;
      bbox_ymax_out <= '0;
`endif
    end else begin
      valid_out <= 1'b0;
      if (state == IDLE) begin
        if (tabulate_in && count < MINP) begin
          stable_cnt     <= '0;
          zone_valid_out <= 1'b0;
        end else if (tabulate_in) begin
          state     <= DIVIDE;
          busy_out  <= 1'b1;
          iter      <= '0;
          div       <= count;
          rem_x     <= '0;
          rem_y     <= '0;
          qx        <= sum_x;
          qy        <= DW'(sum_y);
          best      <= '0;
          best_cnt  <= '0;
          snap_zone <= zone_cnt;
`ifdef CENTROID_BBOX_EN
          sxmin <= xmin;
          sxmax <= xmax;
          symin <= ymin;
          symax <= ymax;
`endif
        end
      end else begin
        overrun_out <= overrun_out | tabulate_in;
        rem_x <= rx_n;
        rem_y <= ry_n;
        qx    <= qx_n;
        qy    <= qy_n;
        iter  <= iter + IW'(1);
        // Strict compare keeps the lowest index on ties.
        if ({1'b0, iter} < ZN && zcur > best_cnt) begin
          best     <= iter[ZW-1:0];
          best_cnt <= zcur;
        end
        if (iter == LAST) begin
          state          <= IDLE;
          busy_out       <= 1'b0;
          valid_out      <= 1'b1;
          x_out          <= qx_n[H_WIDTH-1:0];
          y_out          <= qy_n[V_WIDTH-1:0];
          prev_arg       <= best;
          stable_cnt     <= sc_n;
          zone_valid_out <= sc_n == SF;
          zone_out       <= sc_n == SF ? best : zone_out;
`ifdef CENTROID_BBOX_EN
          bbox_xmin_out <= sxmin;
          bbox_xmax_out <= sxmax;
          bbox_ymin_out <= symin;
          bbox_ymax_out <= symax;
`endif
        end
      end
    end
endmodule

// File: tb/tb_centroid_zone_tracker.sv
// tb_centroid_zone_tracker: directed and random frames checked against a frame-level reference model.
module tb_centroid_zone_tracker;
  logic        clk_in = 1'b0;
  logic        rst_in, valid_in, tabulate_in;
  logic [10:0] x_in, x_out;
  logic [9:0]  y_in, y_out;
  logic        valid_out, zone_valid_out, busy_out, overrun_out;
  logic [1:0]  zone_out;

  centroid_zone_tracker dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out),
    .zone_out(zone_out), .zone_valid_out(zone_valid_out),
    .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int due; longint x; longint y; int z; bit zv;} exp_t;
  exp_t   q[$];
  int     checks = 0, failures = 0, cyc = 0;
  longint m_cnt, m_sx, m_sy;
  int     m_zc[4];
  int     bs = 0, be = -1;
  bit     m_ovr, m_zv;
  int     m_prev, m_stable, m_zone;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_acc();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    for (int i = 0; i < 4; i++) m_zc[i] = 0;
  endtask

  task automatic add_pix(input int x, input int y, input bit v);
    if (v && x < 1024) begin
      m_cnt++; m_sx += x; m_sy += y; m_zc[x / 256]++;
    end
  endtask

  task automatic pix(input int x, input int y, input bit v);
    x_in = 11'(x); y_in = 10'(y); valid_in = v; tabulate_in = 1'b0;
    add_pix(x, y, v);
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) pix(0, 0, 1'b0);
  endtask

  task automatic tab(input int x, input int y, input bit v);
    int  c, arg;
    bit  busy, below;
    c = cyc; busy = c <= be; below = 1'b0;
    if (!busy && m_cnt < 64) begin
      m_stable = 0; m_zv = 1'b0; below = 1'b1;
    end else if (!busy) begin
      arg = 0;
      for (int i = 1; i < 4; i++) if (m_zc[i] > m_zc[arg]) arg = i;
      m_stable = (arg == m_prev) ? ((m_stable >= 3) ? 3 : m_stable + 1) : 1;
      m_prev = arg;
      m_zv = (m_stable == 3);
      if (m_zv) m_zone = arg;
      q.push_back('{c + 33, m_sx / m_cnt, m_sy / m_cnt, m_zone, m_zv});
      bs = c + 1; be = c + 32;
    end
    clear_acc();
    add_pix(x, y, v);
    x_in = 11'(x); y_in = 10'(y); valid_in = v; tabulate_in = 1'b1;
    step();
    tabulate_in = 1'b0; valid_in = 1'b0;
    if (busy) m_ovr = 1'b1;
    if (below) begin
      chk("below_min_zone_valid", zone_valid_out, 0);
      chk("below_min_busy", busy_out, 0);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1; valid_in = 1'b0; tabulate_in = 1'b0; x_in = '0; y_in = '0;
    q.delete(); bs = 0; be = -1; m_ovr = 1'b0;
    m_prev = 0; m_stable = 0; m_zone = 0; m_zv = 1'b0;
    clear_acc();
    #1;
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_zone_out", zone_out, 0);
    chk("rst_zone_valid", zone_valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_overrun", overrun_out, 0);
    step();
    rst_in = 1'b0;
  endtask

  always @(negedge clk_in) if (!rst_in) begin
    exp_t e;
    chk("busy_out", busy_out, (cyc >= bs && cyc <= be) ? 1 : 0);
    chk("overrun_out", overrun_out, m_ovr);
    if (q.size() > 0 && cyc > q[0].due) begin
      chk("report_missing", 0, 1);
      void'(q.pop_front());
    end
    if (valid_out) begin
      if (q.size() == 0) chk("spurious_valid_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("report_cycle", cyc, e.due);
        chk("x_out", x_out, e.x);
        chk("y_out", y_out, e.y);
        chk("zone_out", zone_out, e.z);
        chk("zone_valid_out", zone_valid_out, e.zv);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, n;
    rst_in = 1'b0; valid_in = 1'b0; tabulate_in = 1'b0; x_in = '0; y_in = '0;
    #2;
    do_reset();
    repeat (64) pix(100, 50, 1'b1);
    tab(0, 0, 1'b0);
    idle(40);
    repeat (63) pix(5, 5, 1'b1);
    tab(0, 0, 1'b0);
    idle(40);
    chk("short_frame_no_zone", zone_valid_out, 0);
    for (int f = 0; f < 3; f++) begin
      repeat (100) pix(600, $urandom_range(0, 1023), 1'b1);
      repeat (10) pix(100, 20, 1'b1);
      tab(0, 0, 1'b0);
      idle(36);
    end
    chk("zone_stable_2", zone_out, 2);
    chk("zone_stable_valid", zone_valid_out, 1);
    repeat (100) pix(100, $urandom_range(0, 1023), 1'b1);
    repeat (10) pix(600, 20, 1'b1);
    tab(0, 0, 1'b0);
    idle(36);
    chk("zone_hold_2", zone_out, 2);
    chk("zone_change_invalid", zone_valid_out, 0);
    for (int f = 0; f < 3; f++) begin
      repeat (80) pix(300, $urandom_range(0, 1023), 1'b1);
      repeat (80) pix(900, $urandom_range(0, 1023), 1'b1);
      tab(0, 0, 1'b0);
      idle(36);
    end
    chk("zone_tie_low", zone_out, 1);
    chk("zone_tie_valid", zone_valid_out, 1);
    repeat (64) pix(200, 100, 1'b1);
    tab(0, 0, 1'b0);
    repeat (9) pix(10, 10, 1'b1);
    tab(10, 10, 1'b1);
    idle(40);
    chk("overrun_sticky", overrun_out, 1);
    repeat (64) pix(123, 45, 1'b1);
    k = cyc;
    tab(0, 0, 1'b0);
    idle(14);
    chk("reset_at_t15", cyc - k, 15);
    do_reset();
    idle(40);
    repeat (64) pix(7, 9, 1'b1);
    tab(0, 0, 1'b0);
    idle(40);
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(40, 220);
      repeat (n) pix($urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, 3) != 0);
      tab($urandom_range(0, 2047), $urandom_range(0, 1023), $urandom_range(0, 1) != 0);
      idle($urandom_range(5, 45));
    end
    idle(40);
    chk("pending_reports", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
